// File: rtl/sensor_scan_controller_if.sv
// Bundle of scan-controller signals shared between the sensor environment
// (master) and the scan controller itself (slave).
interface sensor_scan_controller_if #(
  parameter int NCH = 4,
  parameter int DW  = 6
);
  logic              enable;
  logic [NCH*DW-1:0] chData;
  logic [DW-1:0]     anData;
  logic              anWarning;
  logic [NCH-1:0]    ack;
  logic [NCH-1:0]    alarm;
  logic              alarmAny;
  logic [2:0]        curCh;
  logic              scanDone;

  modport master (
    output enable, chData, anWarning, ack,
    input  anData, alarm, alarmAny, curCh, scanDone
  );

  modport slave (
    input  enable, chData, anWarning, ack,
    output anData, alarm, alarmAny, curCh, scanDone
  );
endinterface

// File: rtl/sensor_scan_controller.sv
// Round-robin scanner: feeds each channel's word to a shared warning analyzer,
// filters the results per channel with a persistence counter and latches alarms.
module sensor_scan_controller #(
  parameter int NCH        = 4,
  parameter int DW         = 6,
  parameter int PERSIST    = 3,
  parameter int SAMPLE_DIV = 8
) (
  input logic                     clk,
  input logic                     rst,
  sensor_scan_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, EVAL, WAIT} state_t;

  localparam int          TW        = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int          WAIT_LEN  = (SAMPLE_DIV > 2) ? SAMPLE_DIV - 2 : 1;
  localparam logic [2:0]  LAST_CH   = 3'(NCH - 1);
  localparam logic [2:0]  PERSIST_C = 3'(PERSIST);
  localparam logic [TW-1:0] TIMER_LAST = TW'(WAIT_LEN - 1);

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     curCh_q, curCh_d;
  logic [DW-1:0]  anData_q, anData_d;
  logic [2:0]     cnt_q [NCH];
  logic [2:0]     cnt_d [NCH];
  logic [NCH-1:0] alarm_q, alarm_d;
  logic           alarmAny_q;
  logic           scanDone_q, scanDone_d;

  logic           lastWait;
  logic           advance;
  logic           sampleNow;
  logic [DW-1:0]  selData;

  assign lastWait  = (timer_q == TIMER_LAST);
  assign sampleNow = bus.enable && (state_q == EVAL);
  assign advance   = bus.enable &&
                     (((state_q == EVAL) && (SAMPLE_DIV == 2)) ||
                      ((state_q == WAIT) && lastWait));

  always_comb begin
    selData = '0;
    for (int k = 0; k < NCH; k++) begin
      if (curCh_q == 3'(k)) selData = bus.chData[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.enable) state_d = SETUP;
      SETUP: state_d = bus.enable ? EVAL : IDLE;
      EVAL: begin
        if (!bus.enable)         state_d = IDLE;
        else if (SAMPLE_DIV > 2) state_d = WAIT;
        else                     state_d = SETUP;
      end
      WAIT: begin
        if (!bus.enable)  state_d = IDLE;
        else if (lastWait) state_d = SETUP;
      end
      default: state_d = IDLE;
    endcase
  end

  // A dropped enable abandons the sweep; counters, alarms and anData survive.
  always_comb begin
    timer_d    = '0;
    curCh_d    = curCh_q;
    anData_d   = anData_q;
    scanDone_d = advance && (curCh_q == LAST_CH);
    cnt_d      = cnt_q;
    alarm_d    = alarm_q;

    if ((state_q == WAIT) && bus.enable && !lastWait) timer_d = timer_q + 1'b1;

    if ((state_q != IDLE) && !bus.enable) curCh_d = '0;
    else if (advance) curCh_d = (curCh_q == LAST_CH) ? 3'd0 : curCh_q + 3'd1;

    if ((state_q == SETUP) && bus.enable) anData_d = selData;

    for (int k = 0; k < NCH; k++) begin
      if (sampleNow && (curCh_q == 3'(k))) begin
        if (bus.anWarning)
          cnt_d[k] = (cnt_q[k] >= PERSIST_C) ? PERSIST_C : cnt_q[k] + 3'd1;
        else
          cnt_d[k] = 3'd0;
      end
      // Setting wins over an acknowledge landing on the same edge.
      if (sampleNow && (curCh_q == 3'(k)) && (cnt_d[k] == PERSIST_C))
        alarm_d[k] = 1'b1;
      else if (bus.ack[k] && (cnt_q[k] == 3'd0))
        alarm_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      curCh_q    <= '0;
      anData_q   <= '0;
      alarm_q    <= '0;
      alarmAny_q <= 1'b0;
      scanDone_q <= 1'b0;
      for (int k = 0; k < NCH; k++) cnt_q[k] <= 3'd0;
    end else begin
      timer_q    <= timer_d;
      curCh_q    <= curCh_d;
      anData_q   <= anData_d;
      alarm_q    <= alarm_d;
      alarmAny_q <= |alarm_d;
      scanDone_q <= scanDone_d;
      for (int k = 0; k < NCH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign bus.anData   = anData_q;
  assign bus.alarm    = alarm_q;
  assign bus.alarmAny = alarmAny_q;
  assign bus.curCh    = curCh_q;
  assign bus.scanDone = scanDone_q;

endmodule

// File: tb/tb_sensor_scan_controller.sv
// Directed bench for sensor_scan_controller: a vector table for sweep timing
// and persistence, followed by hand sequences for ack, enable-drop and reset.
module tb_sensor_scan_controller;

  localparam int NCH        = 4;
  localparam int DW         = 6;
  localparam int PERSIST    = 3;
  localparam int SAMPLE_DIV = 8;

  logic clk = 1'b0;
  logic rst;

  sensor_scan_controller_if #(.NCH(NCH), .DW(DW)) bus();

  sensor_scan_controller #(
    .NCH(NCH), .DW(DW), .PERSIST(PERSIST), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Analyzer model: warns on the exact word 6'h02 or whenever bit 5 is set.
  assign bus.anWarning = (bus.anData == 6'h02) || bus.anData[5];

  typedef struct {
    int         t;
    logic       en;
    logic [3:0] ackIn;
    logic [5:0] anData;
    logic [2:0] curCh;
    logic       scanDone;
    logic [3:0] alarm;
    logic       alarmAny;
  } vec_t;

  vec_t vecs[$];
  int   vecCount  = 0;
  int   missCount = 0;
  int   curT;

  task automatic checkVal(string name, logic [7:0] act, logic [7:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s at t=%0d: got %0h, expected %0h", name, curT, act, exp);
    end
  endtask

  task automatic checkOutput(string name, logic [5:0] an, logic [2:0] cc,
                             logic sd, logic [3:0] al, logic any);
    checkVal($sformatf("%s.anData", name), 8'(bus.anData), 8'(an));
    checkVal($sformatf("%s.curCh", name), 8'(bus.curCh), 8'(cc));
    checkVal($sformatf("%s.scanDone", name), 8'(bus.scanDone), 8'(sd));
    checkVal($sformatf("%s.alarm", name), 8'(bus.alarm), 8'(al));
    checkVal($sformatf("%s.alarmAny", name), 8'(bus.alarmAny), 8'(any));
  endtask

  task automatic checkAlarm(string name, logic [3:0] al);
    checkVal($sformatf("%s.alarm", name), 8'(bus.alarm), 8'(al));
    checkVal($sformatf("%s.alarmAny", name), 8'(bus.alarmAny), 8'(|al));
  endtask

  task automatic checkScan(string name, logic [2:0] cc, logic sd);
    checkVal($sformatf("%s.curCh", name), 8'(bus.curCh), 8'(cc));
    checkVal($sformatf("%s.scanDone", name), 8'(bus.scanDone), 8'(sd));
  endtask

  // Advance to 1 time unit after edge number t (edge 0 enters the first SETUP).
  task automatic applyStimulus(int t);
    while (curT < t) begin
      @(posedge clk);
      #1;
      curT++;
    end
  endtask

  task automatic setCh(int k, logic [5:0] val);
    bus.chData[k*DW +: DW] = val;
  endtask

  initial begin
    //            t    en    ack    anData curCh sd    alarm    any
    vecs.push_back('{0,  1'b1, 4'h0, 6'h00, 3'd0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1,  1'b1, 4'h0, 6'h02, 3'd0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{7,  1'b1, 4'h0, 6'h02, 3'd0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{8,  1'b1, 4'h0, 6'h02, 3'd1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{9,  1'b1, 4'h0, 6'h2A, 3'd1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{16, 1'b1, 4'h0, 6'h2A, 3'd2, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{17, 1'b1, 4'h0, 6'h01, 3'd2, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{24, 1'b1, 4'h0, 6'h01, 3'd3, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{25, 1'b1, 4'h0, 6'h10, 3'd3, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{31, 1'b1, 4'h0, 6'h10, 3'd3, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{32, 1'b1, 4'h0, 6'h10, 3'd0, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{33, 1'b1, 4'h0, 6'h02, 3'd0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{64, 1'b1, 4'h0, 6'h10, 3'd0, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{65, 1'b1, 4'h0, 6'h02, 3'd0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{66, 1'b1, 4'h0, 6'h02, 3'd0, 1'b0, 4'b0001, 1'b1});
    vecs.push_back('{73, 1'b1, 4'h0, 6'h2A, 3'd1, 1'b0, 4'b0001, 1'b1});
    vecs.push_back('{74, 1'b1, 4'h0, 6'h2A, 3'd1, 1'b0, 4'b0011, 1'b1});
    vecs.push_back('{96, 1'b1, 4'h0, 6'h10, 3'd0, 1'b1, 4'b0011, 1'b1});

    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.ack     = '0;
    bus.chData  = {6'h10, 6'h01, 6'h2A, 6'h02};
    curT        = -3;
    @(posedge clk); #1;
    checkOutput("reset1", 6'h00, 3'd0, 1'b0, 4'b0000, 1'b0);
    @(posedge clk); #1;
    checkOutput("reset2", 6'h00, 3'd0, 1'b0, 4'b0000, 1'b0);
    rst  = 1'b0;
    curT = -1;

    foreach (vecs[i]) begin
      bus.enable = vecs[i].en;
      bus.ack    = vecs[i].ackIn;
      applyStimulus(vecs[i].t);
      checkOutput($sformatf("vec%0d", i), vecs[i].anData, vecs[i].curCh,
                  vecs[i].scanDone, vecs[i].alarm, vecs[i].alarmAny);
    end

    // Channel 2 starts warning; its third sample coincides with ack[2].
    setCh(2, 6'h22);
    applyStimulus(177);
    bus.ack = 4'b0100;
    applyStimulus(178);
    checkAlarm("setBeatsAck", 4'b0111);
    applyStimulus(200);
    checkAlarm("ackWhileWarn", 4'b0111);
    setCh(2, 6'h01);
    applyStimulus(209);
    checkAlarm("ackBeforeClean", 4'b0111);
    applyStimulus(212);
    checkAlarm("ackAfterClean", 4'b0011);
    bus.ack = '0;

    // Channel 3: two warnings then a clean sample never raises an alarm.
    setCh(3, 6'h22);
    applyStimulus(251);
    checkAlarm("twoWarn", 4'b0011);
    applyStimulus(260);
    setCh(3, 6'h01);
    applyStimulus(283);
    checkAlarm("twoWarnThenClean", 4'b0011);

    // Channel 2 warns twice, then enable drops during its third EVAL.
    setCh(2, 6'h22);
    applyStimulus(369);
    checkScan("preDrop", 3'd2, 1'b0);
    checkVal("preDrop.anData", 8'(bus.anData), 8'h22);
    bus.enable = 1'b0;
    applyStimulus(370);
    checkOutput("dropIdle", 6'h22, 3'd0, 1'b0, 4'b0011, 1'b1);
    applyStimulus(373);
    checkOutput("idleHold", 6'h22, 3'd0, 1'b0, 4'b0011, 1'b1);
    bus.enable = 1'b1;
    applyStimulus(374);
    checkOutput("restart", 6'h22, 3'd0, 1'b0, 4'b0011, 1'b1);
    applyStimulus(375);
    checkVal("restartAn.anData", 8'(bus.anData), 8'h02);
    applyStimulus(391);
    checkAlarm("preThird", 4'b0011);
    applyStimulus(392);
    checkAlarm("thirdAfterDrop", 4'b0111);

    // Clear channel 1 with a held ack, checking the restarted sweep timing too.
    setCh(1, 6'h01);
    bus.ack = 4'b0010;
    applyStimulus(405);
    checkScan("sweepEnd", 3'd3, 1'b0);
    applyStimulus(406);
    checkScan("sweepWrap", 3'd0, 1'b1);
    applyStimulus(407);
    checkScan("wrapPulse", 3'd0, 1'b0);
    applyStimulus(415);
    checkAlarm("ackIgnored", 4'b0111);
    applyStimulus(420);
    checkAlarm("ackCleared", 4'b0101);

    // Reset during WAIT with alarms 0101 pending.
    bus.ack = '0;
    rst     = 1'b1;
    applyStimulus(421);
    checkOutput("midReset", 6'h00, 3'd0, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    applyStimulus(422);
    checkOutput("postResetSetup", 6'h00, 3'd0, 1'b0, 4'b0000, 1'b0);
    applyStimulus(423);
    checkOutput("postResetEval", 6'h02, 3'd0, 1'b0, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
